async_fifo_lvl: RTL and testbench

ASYNC_FIFO_LVL -- requirements
Module: async_fifo_lvl

---
 rtl/async_fifo_lvl_pkg.sv | 26 ++
 rtl/async_fifo_lvl_if.sv | 26 ++
 rtl/async_fifo_lvl_cdc_sync.sv | 26 ++
 rtl/async_fifo_lvl.sv | 130 +++++++++++++
 tb/tb_async_fifo_lvl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_lvl_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer width and Gray-code conversions.
package async_fifo_pkg;

    localparam int PTR_MAX = 16;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic int ptr_width(input int size);
        return $clog2(size) + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ {1'b0, b[PTR_MAX-1:1]};
    endfunction

    // Upper zero bits leave the low-order result unaffected, so narrower pointers can be zero-extended.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_lvl_if.sv
// Handshake, data and level signals of the dual-clock FIFO; slave is the FIFO side.
interface async_fifo_lvl_if #(
    parameter int Width = 12,
    parameter int Size  = 8
);
    import async_fifo_pkg::*;

    localparam int PW = ptr_width(Size);

    logic             r;
    logic [Width-1:0] rd;
    logic             rok;
    logic [PW-1:0]    rlevel;
    logic             ralmost;
    logic             w;
    logic [Width-1:0] wd;
    logic             wok;
    logic [PW-1:0]    wlevel;
    logic             walmost;

    modport master (output r, w, wd,
                    input  rd, rok, rlevel, ralmost, wok, wlevel, walmost);
    modport slave  (input  r, w, wd,
                    output rd, rok, rlevel, ralmost, wok, wlevel, walmost);

endinterface

// File: rtl/async_fifo_lvl_cdc_sync.sv
// Multi-flop synchronizer chain with asynchronous clear, used for pointers and reset release.
module cdc_sync #(
    parameter int W      = 1,
    parameter int Stages = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain_r [Stages];

    // Shift the input through the chain; clear drops every stage at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < Stages; i++) chain_r[i] <= {W{1'b0}};
        end else begin
            chain_r[0] <= d;
            for (int i = 1; i < Stages; i++) chain_r[i] <= chain_r[i-1];
        end
    end

    assign q = chain_r[Stages-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock Gray-pointer FIFO with first-word-fall-through read.
// Level and almost flags exist only when ASYNC_FIFO_LEVEL_EN is defined; otherwise they are tied to zero.
module async_fifo_lvl
    import async_fifo_pkg::*;
#(
    parameter int Width        = 12,
    parameter int Size         = 8,
    parameter int SyncStages   = 2,
    parameter int AlmostThresh = 2
) (
    input  logic          rclk,
    input  logic          dirclr,
    input  logic          wclk,
    async_fifo_lvl_if.slave fifo
);

    localparam int AW = $clog2(Size);
    localparam int PW = ptr_width(Size);

    logic             wrdy_s, rrdy_s, wrst_s, rrst_s;
    logic [PW-1:0]    wbin_r, wgray_r, rbin_r, rgray_r;
    logic [PW-1:0]    wbin_nxt_s, wgray_nxt_s, rbin_nxt_s, rgray_nxt_s;
    logic [PW-1:0]    wgray_sync_s, rgray_sync_s;
    logic             winc_s, rinc_s, full_s, empty_s;
    logic             wok_r, rok_r;
    logic [Width-1:0] mem [Size];

    // Each domain leaves reset only after dirclr has been seen low on two of its own edges.
    cdc_sync #(.W(1), .Stages(2)) u_wrst (.clk(wclk), .clr(dirclr), .d(1'b1), .q(wrdy_s));
    cdc_sync #(.W(1), .Stages(2)) u_rrst (.clk(rclk), .clr(dirclr), .d(1'b1), .q(rrdy_s));
    assign wrst_s = ~wrdy_s;
    assign rrst_s = ~rrdy_s;

    cdc_sync #(.W(PW), .Stages(SyncStages)) u_w2r (.clk(rclk), .clr(rrst_s), .d(wgray_r), .q(wgray_sync_s));
    cdc_sync #(.W(PW), .Stages(SyncStages)) u_r2w (.clk(wclk), .clr(wrst_s), .d(rgray_r), .q(rgray_sync_s));

    assign winc_s      = fifo.w & wok_r;
    assign wbin_nxt_s  = wbin_r + {{(PW-1){1'b0}}, winc_s};
    assign wgray_nxt_s = PW'(bin2gray(ptr_t'(wbin_nxt_s)));
    assign full_s      = (wgray_nxt_s == {~rgray_sync_s[PW-1:PW-2], rgray_sync_s[PW-3:0]});

    // Write pointers and the registered space-available flag.
    always_ff @(posedge wclk or posedge wrst_s) begin
        if (wrst_s) begin
            wbin_r  <= {PW{1'b0}};
            wgray_r <= {PW{1'b0}};
            wok_r   <= 1'b0;
        end else begin
            wbin_r  <= wbin_nxt_s;
            wgray_r <= wgray_nxt_s;
            wok_r   <= ~full_s;
        end
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge wclk) begin
        if (winc_s) begin
            mem[wbin_r[AW-1:0]] <= fifo.wd;
        end
    end

    assign rinc_s      = fifo.r & rok_r;
    assign rbin_nxt_s  = rbin_r + {{(PW-1){1'b0}}, rinc_s};
    assign rgray_nxt_s = PW'(bin2gray(ptr_t'(rbin_nxt_s)));
    assign empty_s     = (wgray_sync_s == rgray_nxt_s);

    // Read pointers and the registered data-available flag.
    always_ff @(posedge rclk or posedge rrst_s) begin
        if (rrst_s) begin
            rbin_r  <= {PW{1'b0}};
            rgray_r <= {PW{1'b0}};
            rok_r   <= 1'b0;
        end else begin
            rbin_r  <= rbin_nxt_s;
            rgray_r <= rgray_nxt_s;
            rok_r   <= ~empty_s;
        end
    end

    assign fifo.rd  = mem[rbin_r[AW-1:0]];
    assign fifo.rok = rok_r;
    assign fifo.wok = wok_r;

`ifdef ASYNC_FIFO_LEVEL_EN
    localparam logic [PW-1:0] WALM = PW'(Size - AlmostThresh);
    localparam logic [PW-1:0] RALM = PW'(AlmostThresh);

    logic [PW-1:0] rbin_wv_s, wbin_rv_s, wlevel_nxt_s, rlevel_nxt_s;
    logic [PW-1:0] wlevel_r, rlevel_r;
    logic          walmost_r, ralmost_r;

    assign rbin_wv_s    = PW'(gray2bin(ptr_t'(rgray_sync_s)));
    assign wbin_rv_s    = PW'(gray2bin(ptr_t'(wgray_sync_s)));
    assign wlevel_nxt_s = wbin_nxt_s - rbin_wv_s;
    assign rlevel_nxt_s = wbin_rv_s - rbin_nxt_s;

    // Write-side level uses the stale read pointer, so it can only over-report occupancy.
    always_ff @(posedge wclk or posedge wrst_s) begin
        if (wrst_s) begin
            wlevel_r  <= {PW{1'b0}};
            walmost_r <= 1'b0;
        end else begin
            wlevel_r  <= wlevel_nxt_s;
            walmost_r <= (wlevel_nxt_s >= WALM);
        end
    end

    // Read-side level uses the stale write pointer, so it can only under-report occupancy.
    always_ff @(posedge rclk or posedge rrst_s) begin
        if (rrst_s) begin
            rlevel_r  <= {PW{1'b0}};
            ralmost_r <= 1'b1;
        end else begin
            rlevel_r  <= rlevel_nxt_s;
            ralmost_r <= (rlevel_nxt_s <= RALM);
        end
    end

    assign fifo.wlevel  = wlevel_r;
    assign fifo.walmost = walmost_r;
    assign fifo.rlevel  = rlevel_r;
    assign fifo.ralmost = ralmost_r;
`else
    assign fifo.wlevel  = {PW{1'b0}};
    assign fifo.walmost = 1'b0;
    assign fifo.rlevel  = {PW{1'b0}};
    assign fifo.ralmost = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Directed and streaming test of async_fifo_lvl (Width=12, Size=8) against a queue scoreboard.
module tb_async_fifo_lvl;

`ifdef ASYNC_FIFO_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif
    localparam int NSTREAM = 1700;

    logic rclk = 1'b0;
    logic wclk = 1'b0;
    logic dirclr = 1'b0;
    int   whp = 5;
    int   rhp = 14;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [11:0] sb [$];
    int   sent, got, cyc, n;
    bit   acc;
    logic [11:0] wdat;

    async_fifo_lvl_if #(.Width(12), .Size(8)) f ();

    async_fifo_lvl #(.Width(12), .Size(8), .SyncStages(2), .AlmostThresh(2)) dut (
        .rclk   (rclk),
        .dirclr (dirclr),
        .wclk   (wclk),
        .fifo   (f)
    );

    always #(whp) wclk = ~wclk;
    always #(rhp) rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] d, output bit ok);
        @(negedge wclk);
        ok = f.wok;
        f.w  = 1'b1;
        f.wd = d;
        if (ok) sb.push_back(d);
        @(posedge wclk);
        #1;
        f.w = 1'b0;
    endtask

    task automatic rd_one(input string tag);
        logic [11:0] e;
        @(negedge rclk);
        chk({tag, "_rok"}, 32'(f.rok), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 12'hxxx;
        chk(tag, 32'(f.rd), 32'(e));
        f.r = 1'b1;
        @(posedge rclk);
        #1;
        f.r = 1'b0;
    endtask

    task automatic wait_rok(input int lim, output int cnt);
        cnt = 0;
        while (cnt < lim) begin
            @(posedge rclk);
            #1;
            cnt++;
            if (f.rok) break;
        end
    endtask

    task automatic wait_wok(input int lim);
        for (int k = 0; k < lim; k++) begin
            @(posedge wclk);
            #1;
            if (f.wok) break;
        end
    endtask

    initial begin
        f.w = 1'b0; f.r = 1'b0; f.wd = 12'h000;
        #1 dirclr = 1'b1;
        #20;
        chk("rst_rok", 32'(f.rok), 32'd0);
        chk("rst_wok", 32'(f.wok), 32'd0);
        chk("rst_rlevel", 32'(f.rlevel), 32'd0);
        chk("rst_wlevel", 32'(f.wlevel), 32'd0);
        chk("rst_ralmost", 32'(f.ralmost), 32'(LVL));
        chk("rst_walmost", 32'(f.walmost), 32'd0);

        @(negedge wclk);
        #1 dirclr = 1'b0;
        wait_wok(3);
        chk("rel_wok", 32'(f.wok), 32'd1);
        repeat (4) @(posedge rclk);

        // single word into an empty FIFO
        wr(12'hABC, acc);
        chk("abc_acc", 32'(acc), 32'd1);
        wait_rok(6, n);
        chk("fwft_latency", 32'(n >= 2 && n <= 4), 32'd1);
        rd_one("abc");
        chk("rok_drop", 32'(f.rok), 32'd0);

        // six words, then level views on both sides
        for (int i = 1; i <= 6; i++) begin
            wr(12'(i), acc);
            chk("fill_wok", 32'(f.wok), 32'd1);
            chk("fill_wlevel", 32'(f.wlevel), LVL ? 32'(i) : 32'd0);
            chk("fill_walmost", 32'(f.walmost), LVL ? 32'(i >= 6) : 32'd0);
        end
        repeat (6) @(posedge rclk);
        #1;
        chk("rlevel6", 32'(f.rlevel), LVL ? 32'd6 : 32'd0);
        chk("ralmost6", 32'(f.ralmost), 32'd0);
        for (int i = 0; i < 4; i++) rd_one("rd4");
        chk("rlevel2", 32'(f.rlevel), LVL ? 32'd2 : 32'd0);
        chk("ralmost2", 32'(f.ralmost), 32'(LVL));
        repeat (8) @(posedge wclk);

        // top up to full; the overflow attempt must be dropped
        for (int j = 1; j <= 6; j++) begin
            wr(12'(6 + j), acc);
            chk("top_acc", 32'(acc), 32'd1);
            chk("top_wok", 32'(f.wok), 32'(j < 6));
            chk("top_wlevel", 32'(f.wlevel), LVL ? 32'(2 + j) : 32'd0);
        end
        wr(12'hFFF, acc);
        chk("ovf_ignored", 32'(acc), 32'd0);
        rd_one("free1");
        wait_wok(4);
        chk("wok_back", 32'(f.wok), 32'd1);
        while (sb.size() > 0) rd_one("drain");
        chk("drain_empty", 32'(f.rok), 32'd0);

        // random streaming at a 3:7 clock ratio
        whp = 15;
        rhp = 35;
        sent = 0; got = 0; cyc = 0;
        fork
            begin
                while (sent < NSTREAM) begin
                    @(negedge wclk);
                    if (f.wok && $urandom_range(0, 3) != 0) begin
                        wdat = 12'($urandom);
                        f.w = 1'b1;
                        f.wd = wdat;
                        sb.push_back(wdat);
                        sent++;
                    end else begin
                        f.w = 1'b0;
                    end
                end
                @(negedge wclk);
                f.w = 1'b0;
            end
            begin
                while (got < NSTREAM && cyc < 20000) begin
                    @(negedge rclk);
                    cyc++;
                    f.r = 1'b0;
                    if (f.rok && $urandom_range(0, 3) != 0) begin
                        if (sb.size() == 0) chk("underflow", 32'd1, 32'd0);
                        else chk("stream", 32'(f.rd), 32'(sb.pop_front()));
                        f.r = 1'b1;
                        got++;
                    end
                end
                @(negedge rclk);
                f.r = 1'b0;
            end
        join
        chk("stream_count", 32'(got), 32'(NSTREAM));
        repeat (6) @(posedge rclk);
        #1;
        chk("stream_empty", 32'(f.rok), 32'd0);

        // reset pulse while full
        whp = 5;
        rhp = 14;
        sb.delete();
        for (int i = 0; i < 8; i++) wr(12'h100 + 12'(i), acc);
        chk("full_wok", 32'(f.wok), 32'd0);
        wait_rok(8, n);
        chk("full_rok", 32'(f.rok), 32'd1);
        @(negedge wclk);
        #2 dirclr = 1'b1;
        #1;
        chk("pulse_rok", 32'(f.rok), 32'd0);
        chk("pulse_wok", 32'(f.wok), 32'd0);
        chk("pulse_ralmost", 32'(f.ralmost), 32'(LVL));
        chk("pulse_wlevel", 32'(f.wlevel), 32'd0);
        dirclr = 1'b0;
        sb.delete();
        wait_wok(3);
        chk("post_wok", 32'(f.wok), 32'd1);
        wr(12'h5A5, acc);
        wait_rok(10, n);
        rd_one("post_first");
        chk("post_empty", 32'(f.rok), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
